// File: rtl/result_uart_tx.sv
// result_uart_tx: buffers 5-bit classification results in a small FIFO and
// sends each one as an 8N1 UART frame. A baud counter acts as the bit-timing
// clock enable, so the whole block runs on the system clock.
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_50M,
  input  logic       i_rst_n,
  input  logic [4:0] i_result_data,
  input  logic       i_result_valid,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_fifo_full,
  output logic       o_overflow
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BAUD_LAST_INT = CLKS_PER_BIT - 1;
  localparam logic [CW-1:0] BAUD_LAST = BAUD_LAST_INT[CW-1:0];
  localparam logic [AW:0]   DEPTH     = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          full_reg;
  logic          overflow_reg;

  // Transmitter state
  state_t        state_reg;
  logic [CW-1:0] baud_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          busy_reg;

  logic pop;
  logic push;
  logic baud_wrap;

  // A pop frees a slot in the same cycle, so a write to a full FIFO is still
  // accepted when the transmitter is taking the head at that moment.
  always_comb begin
    pop        = (state_reg == IDLE) && (count_reg != '0);
    push       = i_result_valid && ((count_reg != DEPTH) || pop);
    baud_wrap  = (baud_cnt_reg == BAUD_LAST);
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Result storage; no reset so it maps onto plain memory
  always_ff @(posedge clk_50M) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {3'b000, i_result_data};
    end
  end

  // FIFO pointers, occupancy, full flag and sticky overflow flag
  always_ff @(posedge clk_50M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (i_result_valid && !push) begin
        overflow_reg <= 1'b1;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH);
    end
  end

  // Frame sequencer with registered line and busy outputs
  always_ff @(posedge clk_50M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      busy_reg <= (state_reg != IDLE) || (count_reg != '0);

      case (state_reg)
        START:   tx_reg <= 1'b0;
        DATA:    tx_reg <= shift_reg[0];
        default: tx_reg <= 1'b1;
      endcase

      case (state_reg)
        IDLE: begin
          if (pop) begin
            shift_reg    <= fifo_mem[rd_ptr_reg];
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            state_reg    <= START;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_cnt_reg <= '0;
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_cnt_reg <= '0;
            shift_reg    <= shift_reg >> 1;
            bit_idx_reg  <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        default: begin
          if (baud_wrap) begin
            baud_cnt_reg <= '0;
            state_reg    <= IDLE;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_tx        = tx_reg;
  assign o_busy      = busy_reg;
  assign o_fifo_full = full_reg;
  assign o_overflow  = overflow_reg;

endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: directed, table-driven bench for result_uart_tx with a
// short baud period so whole frames can be followed cycle by cycle.
module tb_result_uart_tx;

  localparam int CPB = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk_50M;
  logic       i_rst_n;
  logic [4:0] i_result_data;
  logic       i_result_valid;
  logic       o_tx;
  logic       o_busy;
  logic       o_fifo_full;
  logic       o_overflow;

  int checks;
  int failures;

  typedef struct {
    logic [4:0] data;
    logic [7:0] byte_exp;
  } vec_t;

  vec_t vecs [5];

  result_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_50M       (clk_50M),
    .i_rst_n       (i_rst_n),
    .i_result_data (i_result_data),
    .i_result_valid(i_result_valid),
    .o_tx          (o_tx),
    .o_busy        (o_busy),
    .o_fifo_full   (o_fifo_full),
    .o_overflow    (o_overflow)
  );

  initial clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Follows line positions first..last of a frame (position 0 = first start-bit
  // cycle), one sample per cycle, and reports one comparison per bit period.
  task automatic check_frame(input logic [7:0] b, input int first, input int last, input string name);
    logic exp_lvl [10];
    logic act_lvl [10];
    logic busy_dropped;
    int   bi;
    logic e;
    busy_dropped = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_lvl[k] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      act_lvl[k] = exp_lvl[k];
    end
    for (int i = first; i <= last; i++) begin
      bi = i / CPB;
      e  = exp_lvl[bi];
      if (o_tx !== e) act_lvl[bi] = o_tx;
      if (o_busy !== 1'b1) busy_dropped = 1'b1;
      tick();
    end
    for (int k = first / CPB; k <= last / CPB; k++) begin
      check($sformatf("%s_bit%0d", name, k), act_lvl[k], exp_lvl[k]);
    end
    check($sformatf("%s_busy_held", name), busy_dropped, 1'b0);
    $display("frame %s byte=0x%02h positions %0d..%0d followed", name, b, first, last);
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    while (o_tx !== 1'b0 && n < 5000) begin
      tick();
      n++;
    end
  endtask

  // One write from idle: line falls exactly two edges after the write edge,
  // busy drops on the edge that ends the stop bit.
  task automatic send_one(input logic [4:0] d, input logic [7:0] b, input string name);
    i_result_data  = d;
    i_result_valid = 1'b1;
    tick();
    i_result_valid = 1'b0;
    check({name, "_lat_e0"}, o_tx, 1'b1);
    tick();
    check({name, "_lat_e1"}, o_tx, 1'b1);
    check({name, "_busy_rise"}, o_busy, 1'b1);
    tick();
    check_frame(b, 0, FRAME - 1, name);
    check({name, "_busy_fall"}, o_busy, 1'b0);
    check({name, "_idle_line"}, o_tx, 1'b1);
    repeat (3) tick();
  endtask

  initial begin
    int n;
    logic bad_tx;
    logic bad_busy;
    logic [4:0]  burst_data [6];
    logic        full_exp [6];
    logic        ovf_exp [6];
    logic [7:0]  tail_bytes [4];

    checks = 0;
    failures = 0;
    vecs[0] = '{5'd19, 8'h13};
    vecs[1] = '{5'd31, 8'h1F};
    vecs[2] = '{5'd0,  8'h00};
    vecs[3] = '{5'd10, 8'h0A};
    vecs[4] = '{5'd21, 8'h15};
    burst_data = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    full_exp   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ovf_exp    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    i_rst_n = 1'b0;
    i_result_data = '0;
    i_result_valid = 1'b0;
    repeat (3) tick();
    check("rst_tx", o_tx, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_full", o_fifo_full, 1'b0);
    check("rst_ovf", o_overflow, 1'b0);
    #2;
    i_rst_n = 1'b1;
    repeat (2) tick();

    // Single results from idle, including the maximum code
    for (int k = 0; k < 5; k++) begin
      send_one(vecs[k].data, vecs[k].byte_exp, $sformatf("single%0d", k));
    end

    // Burst of six writes: the first is popped at once, 2..5 fill, 6 drops
    i_result_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      i_result_data = burst_data[k];
      tick();
      check($sformatf("burst_full_w%0d", k + 1), o_fifo_full, full_exp[k]);
      check($sformatf("burst_ovf_w%0d", k + 1), o_overflow, ovf_exp[k]);
    end
    i_result_valid = 1'b0;
    check_frame(8'h01, 3, FRAME - 1, "burst1");
    tail_bytes = '{8'h02, 8'h03, 8'h04, 8'h05};
    for (int k = 0; k < 4; k++) begin
      wait_fall(n);
      check($sformatf("burst_gap%0d", k + 2), n, 1);
      check_frame(tail_bytes[k], 0, FRAME - 1, $sformatf("burst%0d", k + 2));
    end
    check("burst_busy_fall", o_busy, 1'b0);
    check("burst_ovf_sticky", o_overflow, 1'b1);
    repeat (3) tick();

    // Reset during data bit 3 with a full FIFO behind the frame
    i_result_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_result_data = 5'd21 + 5'(k);
      tick();
    end
    i_result_valid = 1'b0;
    check_frame(8'h15, 2, 4 * CPB + 1, "rstframe");
    check("rstmid_line_low", o_tx, 1'b0);
    check("rstmid_full_before", o_fifo_full, 1'b1);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("rstmid_tx", o_tx, 1'b1);
    check("rstmid_busy", o_busy, 1'b0);
    check("rstmid_full", o_fifo_full, 1'b0);
    check("rstmid_ovf", o_overflow, 1'b0);
    #2;
    i_rst_n = 1'b1;
    tick();
    bad_tx = 1'b0;
    bad_busy = 1'b0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (o_tx !== 1'b1) bad_tx = 1'b1;
      if (o_busy !== 1'b0) bad_busy = 1'b1;
      tick();
    end
    check("post_rst_no_frame", bad_tx, 1'b0);
    check("post_rst_not_busy", bad_busy, 1'b0);
    send_one(5'd9, 8'h09, "fresh");

    // Write accepted on the very cycle the full FIFO's head is popped
    i_result_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_result_data = burst_data[k];
      tick();
    end
    i_result_valid = 1'b0;
    check("pp_full_filled", o_fifo_full, 1'b1);
    check_frame(8'h01, 2, FRAME - 2, "pp1");
    i_result_data = 5'd7;
    i_result_valid = 1'b1;
    check("pp_full_before", o_fifo_full, 1'b1);
    tick();
    i_result_valid = 1'b0;
    check("pp_full_after", o_fifo_full, 1'b1);
    check("pp_ovf_after", o_overflow, 1'b0);
    check("pp_stop_tail", o_tx, 1'b1);
    tick();
    check_frame(8'h02, 0, FRAME - 1, "pp2");
    tail_bytes = '{8'h03, 8'h04, 8'h05, 8'h07};
    for (int k = 0; k < 4; k++) begin
      wait_fall(n);
      check($sformatf("pp_gap%0d", k), n, 1);
      check_frame(tail_bytes[k], 0, FRAME - 1, $sformatf("pp_tail%0d", k));
    end
    check("pp_busy_fall", o_busy, 1'b0);
    check("pp_ovf_end", o_overflow, 1'b0);
    check("pp_full_end", o_fifo_full, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
